// File: rtl/imem_loader.sv
// Purpose : streams 8-bit instruction codes into the instruction memory from address 0, holding fetch stalled meanwhile.
// Latency : a byte accepted on edge Tn is written during Tn..Tn+1; done/core_hold release two edges after the final byte.
// Backpressure: in_ready is high only in LOAD; it drops on the terminating acceptance, so later bytes are never taken.
module imem_loader #(
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  input  logic              in_last,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              core_hold,
  output logic              done,
  output logic [ADDR_W:0]   count,
  output logic              full
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_FLUSH = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;

  // Registered outputs and the write pointer.
  logic [ADDR_W-1:0]   r_ptr;
  logic                r_in_ready;
  logic                r_mem_we;
  logic [ADDR_W-1:0]   r_mem_addr;
  logic [7:0]          r_mem_wdata;
  logic                r_core_hold;
  logic                r_done;
  logic [ADDR_W:0]     r_count;
  logic                r_full;

  // Next values computed by the output process.
  logic [ADDR_W-1:0]   w_ptr_nxt;
  logic                w_in_ready_nxt;
  logic                w_mem_we_nxt;
  logic [ADDR_W-1:0]   w_mem_addr_nxt;
  logic [7:0]          w_mem_wdata_nxt;
  logic                w_core_hold_nxt;
  logic                w_done_nxt;
  logic [ADDR_W:0]     w_count_nxt;
  logic                w_full_nxt;

  logic                w_accept;
  logic                w_at_end;
  logic                w_term;
  logic                w_start_ok;

  // A byte is taken only while loading with ready advertised; the last
  // memory slot or an in_last byte closes the load.
  assign w_accept   = (r_state == S_LOAD) & r_in_ready & in_valid;
  assign w_at_end   = (r_ptr == ADDR_W'(DEPTH - 1));
  assign w_term     = w_accept & (in_last | w_at_end);
  assign w_start_ok = start & ((r_state == S_IDLE) | (r_state == S_DONE));

  // State register with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state decode: start only matters in IDLE/DONE, FLUSH is one cycle.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (start)  w_state_nxt = S_LOAD;
      S_LOAD:  if (w_term) w_state_nxt = S_FLUSH;
      S_FLUSH: w_state_nxt = S_DONE;
      S_DONE:  if (start)  w_state_nxt = S_LOAD;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Output decode: next values of every registered output; most hold by default.
  always_comb begin
    w_ptr_nxt       = r_ptr;
    w_in_ready_nxt  = r_in_ready;
    w_mem_we_nxt    = 1'b0;
    w_mem_addr_nxt  = r_mem_addr;
    w_mem_wdata_nxt = r_mem_wdata;
    w_core_hold_nxt = r_core_hold;
    w_done_nxt      = r_done;
    w_count_nxt     = r_count;
    w_full_nxt      = r_full;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (w_start_ok) begin
          w_ptr_nxt       = '0;
          w_count_nxt     = '0;
          w_done_nxt      = 1'b0;
          w_full_nxt      = 1'b0;
          w_core_hold_nxt = 1'b1;
          w_in_ready_nxt  = 1'b1;
        end
      end
      S_LOAD: begin
        w_in_ready_nxt = 1'b1;
        if (w_accept) begin
          w_mem_we_nxt    = 1'b1;
          w_mem_addr_nxt  = r_ptr;
          w_mem_wdata_nxt = in_data;
          w_count_nxt     = r_count + (ADDR_W + 1)'(1);
          // The pointer parks on the last slot rather than wrapping.
          w_ptr_nxt       = w_at_end ? r_ptr : r_ptr + ADDR_W'(1);
          if (w_term) begin
            w_in_ready_nxt = 1'b0;
            w_full_nxt     = w_at_end & ~in_last;
          end
        end
      end
      S_FLUSH: begin
        w_in_ready_nxt  = 1'b0;
        w_core_hold_nxt = 1'b0;
        w_done_nxt      = 1'b1;
      end
      default: begin
        w_in_ready_nxt  = 1'b0;
        w_core_hold_nxt = 1'b0;
      end
    endcase
  end

  // Output and pointer registers; everything clears immediately on reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_ptr       <= '0;
      r_in_ready  <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_core_hold <= 1'b0;
      r_done      <= 1'b0;
      r_count     <= '0;
      r_full      <= 1'b0;
    end else begin
      r_ptr       <= w_ptr_nxt;
      r_in_ready  <= w_in_ready_nxt;
      r_mem_we    <= w_mem_we_nxt;
      r_mem_addr  <= w_mem_addr_nxt;
      r_mem_wdata <= w_mem_wdata_nxt;
      r_core_hold <= w_core_hold_nxt;
      r_done      <= w_done_nxt;
      r_count     <= w_count_nxt;
      r_full      <= w_full_nxt;
    end
  end

  assign in_ready  = r_in_ready;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign core_hold = r_core_hold;
  assign done      = r_done;
  assign count     = r_count;
  assign full      = r_full;

endmodule

// File: tb/tb_imem_loader.sv
// Purpose : directed bench for imem_loader with a write scoreboard.
// Latency : expects a write one cycle after each acceptance, done two edges after the final byte.
// Backpressure: sends only while in_ready is seen high; a bounded wait reports a failure.
module tb_imem_loader;
  localparam int DEPTH  = 8;
  localparam int ADDR_W = 3;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              start = 1'b0;
  logic              in_valid = 1'b0;
  logic [7:0]        in_data = 8'h00;
  logic              in_last = 1'b0;
  logic              in_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_wdata;
  logic              core_hold;
  logic              done;
  logic [ADDR_W:0]   count;
  logic              full;

  imem_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .reset(reset), .start(start), .in_valid(in_valid),
    .in_data(in_data), .in_last(in_last), .in_ready(in_ready),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .core_hold(core_hold), .done(done), .count(count), .full(full)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [7:0]        data;
  } wr_t;

  wr_t sb_q[$];
  int  n_assert = 0;
  int  n_fail   = 0;
  int  exp_cnt  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every write strobe must match the oldest pending expectation.
  always @(negedge clk) begin
    wr_t e;
    if (reset === 1'b1 && mem_we === 1'b1) begin
      check("sb_has_entry", 32'(sb_q.size() != 0), 32'd1);
      if (sb_q.size() != 0) begin
        e = sb_q.pop_front();
        check("sb_addr", 32'(mem_addr), 32'(e.addr));
        check("sb_data", 32'(mem_wdata), 32'(e.data));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_in_ready"},  32'(in_ready),  32'd0);
    check({tag, "_mem_we"},    32'(mem_we),    32'd0);
    check({tag, "_mem_addr"},  32'(mem_addr),  32'd0);
    check({tag, "_mem_wdata"}, 32'(mem_wdata), 32'd0);
    check({tag, "_core_hold"}, 32'(core_hold), 32'd0);
    check({tag, "_done"},      32'(done),      32'd0);
    check({tag, "_count"},     32'(count),     32'd0);
    check({tag, "_full"},      32'(full),      32'd0);
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
    exp_cnt = 0;
    check("start_in_ready",  32'(in_ready),  32'd1);
    check("start_core_hold", 32'(core_hold), 32'd1);
    check("start_done",      32'(done),      32'd0);
    check("start_full",      32'(full),      32'd0);
    check("start_count",     32'(count),     32'd0);
  endtask

  task automatic send(input logic [7:0] d, input logic last);
    int  guard;
    wr_t e;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    guard    = 0;
    while (in_ready !== 1'b1 && guard < 20) begin
      tick();
      guard++;
    end
    check("ready_before_accept", 32'(in_ready), 32'd1);
    if (in_ready === 1'b1) begin
      e.addr = ADDR_W'(exp_cnt);
      e.data = d;
      sb_q.push_back(e);
      tick();
      exp_cnt++;
      check("wr_strobe", 32'(mem_we),   32'd1);
      check("wr_addr",   32'(mem_addr), 32'(e.addr));
      check("wr_count",  32'(count),    32'(exp_cnt));
    end
  endtask

  task automatic finish_check(input logic exp_full);
    in_valid = 1'b0;
    in_last  = 1'b0;
    check("flush_in_ready",  32'(in_ready),  32'd0);
    check("flush_core_hold", 32'(core_hold), 32'd1);
    check("flush_done",      32'(done),      32'd0);
    tick();
    check("done_done",      32'(done),        32'd1);
    check("done_core_hold", 32'(core_hold),   32'd0);
    check("done_mem_we",    32'(mem_we),      32'd0);
    check("done_count",     32'(count),       32'(exp_cnt));
    check("done_full",      32'(full),        32'(exp_full));
    check("done_sb_empty",  32'(sb_q.size()), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    // Reset state.
    #2 reset = 1'b0;
    #10;
    check_all_zero("reset");
    @(negedge clk);
    reset = 1'b1;
    tick();
    check_all_zero("post_reset_idle");

    // Back-to-back six-byte program.
    do_start();
    send(8'h12, 1'b0);
    send(8'h52, 1'b0);
    send(8'h5A, 1'b0);
    send(8'hC5, 1'b0);
    send(8'h13, 1'b0);
    send(8'h53, 1'b1);
    finish_check(1'b0);

    // Fill all DEPTH slots without in_last; a ninth byte must be refused.
    do_start();
    for (int i = 1; i <= DEPTH; i++) send(8'(i), 1'b0);
    in_data = 8'h09;
    check("full_in_ready", 32'(in_ready), 32'd0);
    tick();
    check("full_done",  32'(done),  32'd1);
    check("full_full",  32'(full),  32'd1);
    check("full_count", 32'(count), 32'd8);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("ninth_no_we",    32'(mem_we),   32'd0);
      check("ninth_count",    32'(count),    32'd8);
      check("ninth_in_ready", 32'(in_ready), 32'd0);
    end
    in_valid = 1'b0;

    // Restart from DONE (full clears in do_start), then a gapped stream.
    do_start();
    send(8'hAA, 1'b0);
    in_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      check("gap_no_we",     32'(mem_we),    32'd0);
      check("gap_core_hold", 32'(core_hold), 32'd1);
      check("gap_in_ready",  32'(in_ready),  32'd1);
    end
    send(8'hBB, 1'b0);
    send(8'hCC, 1'b1);
    finish_check(1'b0);

    // Reset mid-load after three accepted bytes.
    do_start();
    send(8'h11, 1'b0);
    send(8'h22, 1'b0);
    send(8'h33, 1'b0);
    in_valid = 1'b0;
    #1 reset = 1'b0;
    #1;
    check_all_zero("midload_reset");
    sb_q.delete();
    @(negedge clk);
    reset = 1'b1;
    tick();
    check("after_reset_idle_ready", 32'(in_ready), 32'd0);
    do_start();
    send(8'h44, 1'b0);

    // start during LOAD is ignored.
    in_valid = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("load_start_count",     32'(count),     32'd1);
    check("load_start_in_ready",  32'(in_ready),  32'd1);
    check("load_start_done",      32'(done),      32'd0);
    check("load_start_core_hold", 32'(core_hold), 32'd1);
    send(8'h55, 1'b1);
    finish_check(1'b0);

    // Single-byte program.
    do_start();
    send(8'h53, 1'b1);
    finish_check(1'b0);

    repeat (2) tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/imem_loader.md
# imem_loader

Write-side companion to the instruction fetch path. It accepts a byte stream of 8-bit instruction codes over a valid/ready handshake and writes them sequentially into the byte-addressable instruction memory, starting at address 0. While loading, it holds the fetch stage stalled. It releases the stall one cycle after the last write has landed, so the core begins fetching from a fully programmed memory.

## Interface
- DEPTH, 8, number of instruction memory locations; a power of two, minimum 2
- ADDR_W, 3, memory address width; equals log2(DEPTH)
- clk  input  1  clock; all state updates on the rising edge
- reset  input  1  reset, asynchronous, active-low
- start  input  1  load request; sampled only in IDLE or DONE
- in_valid  input  1  in_data holds a valid instruction byte
- in_data  input  8  instruction code to store
- in_last  input  1  qualifies in_data as the final byte of the program
- in_ready  output  1  loader accepts a byte this cycle
- mem_we  output  1  write strobe to instruction memory, one cycle per byte
- mem_addr  output  ADDR_W  write address
- mem_wdata  output  8  write data
- core_hold  output  1  stalls PC update in the fetch stage while high
- done  output  1  load complete; stays high until the next start
- count  output  ADDR_W+1  number of bytes written in the current or last load
- full  output  1  load ended because DEPTH bytes were written without in_last

## Operation
- States: IDLE, LOAD, FLUSH, DONE. All outputs are registered.
- Reset values: state IDLE, in_ready 0, mem_we 0, mem_addr 0, mem_wdata 0, core_hold 0, done 0, count 0, full 0.
- IDLE/DONE with start=1:
  - Next state is LOAD.
  - Write pointer and count clear to 0; done and full clear to 0.
  - core_hold goes to 1 and in_ready goes to 1.
- LOAD:
  - in_ready=1.
  - A byte is accepted on a clock edge with in_valid & in_ready.
  - On acceptance, the next cycle has mem_we=1, mem_addr=pointer and mem_wdata=in_data. The pointer then increments and count increments.
  - in_valid=0 results in no write and no state change.
  - start is ignored in LOAD and FLUSH.
- Terminating acceptance: a byte accepted with in_last=1, or the byte written to address DEPTH-1, ends the load.
  - The next state is FLUSH and in_ready drops to 0.
  - full=1 if the load ended at DEPTH-1 with in_last=0.
  - If in_last=1 at address DEPTH-1, full stays 0.
- FLUSH: lasts exactly one cycle, in which the last mem_we pulse is presented. Next state is DONE.
- DONE:
  - done=1, core_hold=0, in_ready=0, mem_we=0.
  - count and full hold their values.
  - mem_addr and mem_wdata hold their last values.
- Wrap-around: the pointer never wraps within one load. A new start restarts at address 0. Unwritten locations are left untouched.
- Reset mid-load: all outputs return to their reset values immediately (asynchronous). Any partially written memory is not cleared.
- The memory is written only through mem_we. The loader never reads memory.

## Timing
- start sampled at edge T0: at T0+1, in_ready=1 and core_hold=1.
- Byte accepted at edge Tn: mem_we=1 during Tn+1..Tn+2, with count=n+1 from Tn+1.
- Back-to-back throughput is 1 byte per cycle. mem_we stays high continuously while in_valid is held high.
- Final byte accepted at edge Tf: in_ready=0 from Tf+1, the last mem_we is high from Tf+1, and done=1 / core_hold=0 from Tf+2.
- start and terminating acceptance cannot coincide, because start is ignored in LOAD.
- start asserted in the same cycle as the DONE entry edge is not seen until DONE is registered.
- Reset deassertion is sampled synchronously. The first start is honoured on the first edge after reset goes high.

## Test plan
- Load 12,52,5A,C5,13,53 with in_last on 53, in_valid held high → mem_we pulses on 6 consecutive cycles at addresses 0..5 with those data; done=1 and core_hold=0 two cycles after 53 is accepted; count=6, full=0.
- Eight bytes 01..08, no in_last, DEPTH=8 → writes to addresses 0..7, in_ready low after the 8th acceptance, full=1, count=8; a 9th in_valid is never accepted.
- Gapped stream: in_valid toggles 1,0,0,1,1 with bytes AA,BB,CC (in_last on CC) → writes only on accepted cycles to addresses 0,1,2; core_hold stays high throughout the gaps.
- Reset pulsed low after 3 accepted bytes → all outputs immediately go to 0 and state is IDLE; a new start then writes from address 0 with count restarting at 1.
- start pulsed during LOAD → ignored, pointer unchanged; start in DONE → done and full clear, core_hold=1 next cycle, reload begins at address 0.
- Single-byte program 53 with in_last → one mem_we at address 0, count=1, done asserted at the second edge after acceptance.
